// File: rtl/wb_nn_port.sv
// Wishbone slave port that feeds a sample FIFO into an NN core and captures
// its result pulses. It provides a CTRL/STATUS register pair, a push-only
// IN_DATA window, a read-to-clear OUT_DATA window and a level interrupt.
module wb_nn_port #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SAMPLE_W  = 16,
    parameter int          DEPTH     = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic                wbs_cyc_i,
    input  logic                wbs_stb_i,
    input  logic                wbs_we_i,
    input  logic [3:0]          wbs_sel_i,
    input  logic [31:0]         wbs_adr_i,
    input  logic [31:0]         wbs_dat_i,
    output logic                wbs_ack_o,
    output logic [31:0]         wbs_dat_o,
    output logic                smp_valid_o,
    input  logic                smp_ready_i,
    output logic [SAMPLE_W-1:0] smp_data_o,
    input  logic                res_valid_i,
    input  logic [SAMPLE_W-1:0] res_data_i,
    output logic                irq_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] OFF_CTRL   = 6'd0;
    localparam logic [5:0] OFF_STATUS = 6'd1;
    localparam logic [5:0] OFF_IN     = 6'd2;
    localparam logic [5:0] OFF_OUT    = 6'd3;

    logic                ack_q, ack_d;
    logic                done_q, done_d;
    logic                enable_q, enable_d;
    logic                irq_en_q, irq_en_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                res_valid_q, res_valid_d;
    logic                res_overrun_q, res_overrun_d;
    logic [SAMPLE_W-1:0] res_data_q, res_data_d;
    logic                irq_q, irq_d;
    logic [SAMPLE_W-1:0] mem_q [DEPTH];

    logic       hit;
    logic [5:0] offset;
    logic       acc_wr, acc_rd;
    logic       ctrl_wr, status_wr, in_wr, out_rd;
    logic       clear, full, empty, push_ok, pop;
    logic [31:0] rdata;
    logic       unused_bits;

    // Address decode; bus inputs are held by the master through the ack cycle
    always_comb begin
        hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        offset    = wbs_adr_i[7:2];
        acc_wr    = ack_q & hit & wbs_we_i;
        acc_rd    = ack_q & hit & ~wbs_we_i;
        ctrl_wr   = acc_wr & (offset == OFF_CTRL) & wbs_sel_i[0];
        status_wr = acc_wr & (offset == OFF_STATUS) & wbs_sel_i[1];
        in_wr     = acc_wr & (offset == OFF_IN) & (|wbs_sel_i);
        out_rd    = acc_rd & (offset == OFF_OUT);
        clear     = ctrl_wr & wbs_dat_i[2];
        full      = (count_q == CW'(DEPTH));
        empty     = (count_q == '0);
        push_ok   = in_wr & ~full;
        pop       = smp_valid_o & smp_ready_i;
    end

    // Single-cycle ack; done_q blocks a re-ack until the strobe is released
    always_comb begin
        ack_d  = hit & ~ack_q & ~done_q;
        done_d = done_q;
        if (ack_q) begin
            done_d = 1'b1;
        end else if (!(wbs_cyc_i && wbs_stb_i)) begin
            done_d = 1'b0;
        end
    end

    // Control register and FIFO pointer/count bookkeeping; clear wins
    always_comb begin
        enable_d = enable_q;
        irq_en_d = irq_en_q;
        if (ctrl_wr) begin
            enable_d = wbs_dat_i[0];
            irq_en_d = wbs_dat_i[1];
        end
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
        overflow_d = overflow_q;
        if (status_wr && wbs_dat_i[10]) begin
            overflow_d = 1'b0;
        end
        if (in_wr && full) begin
            overflow_d = 1'b1;
        end
    end

    // Result capture: new pulse overwrites, overrun only if unread data is lost
    always_comb begin
        res_data_d    = res_valid_i ? res_data_i : res_data_q;
        res_valid_d   = res_valid_q;
        if (out_rd) begin
            res_valid_d = 1'b0;
        end
        if (res_valid_i) begin
            res_valid_d = 1'b1;
        end
        res_overrun_d = res_overrun_q;
        if (status_wr && wbs_dat_i[12]) begin
            res_overrun_d = 1'b0;
        end
        if (res_valid_i && res_valid_q && !out_rd) begin
            res_overrun_d = 1'b1;
        end
        irq_d = irq_en_q & (res_valid_q | overflow_q | res_overrun_q);
    end

    // Read mux, driven only during the ack cycle of a read
    always_comb begin
        rdata = '0;
        if (acc_rd) begin
            case (offset)
                OFF_CTRL:   rdata = {30'd0, irq_en_q, enable_q};
                OFF_STATUS: rdata = {19'd0, res_overrun_q, res_valid_q, overflow_q,
                                     full, empty, 8'(count_q)};
                OFF_OUT:    rdata = 32'(res_data_q);
                default:    rdata = '0;
            endcase
        end
    end

    assign wbs_ack_o   = ack_q;
    assign wbs_dat_o   = rdata;
    assign smp_valid_o = enable_q & ~empty;
    assign smp_data_o  = mem_q[rd_ptr_q];
    assign irq_o       = irq_q;
    assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i};

    // Control and status state, cleared asynchronously
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            ack_q         <= 1'b0;
            done_q        <= 1'b0;
            enable_q      <= 1'b0;
            irq_en_q      <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            res_valid_q   <= 1'b0;
            res_overrun_q <= 1'b0;
            res_data_q    <= '0;
            irq_q         <= 1'b0;
        end else begin
            ack_q         <= ack_d;
            done_q        <= done_d;
            enable_q      <= enable_d;
            irq_en_q      <= irq_en_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            res_valid_q   <= res_valid_d;
            res_overrun_q <= res_overrun_d;
            res_data_q    <= res_data_d;
            irq_q         <= irq_d;
        end
    end

    // FIFO storage; contents are only meaningful below count_q so no reset
    always_ff @(posedge wb_clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wbs_dat_i[SAMPLE_W-1:0];
        end
    end

endmodule

// File: tb/tb_wb_nn_port.sv
// Directed bench for wb_nn_port with default parameters.
module tb_wb_nn_port;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_IN   = BASE + 32'h8;
    localparam logic [31:0] A_OUT  = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] adr = '0, wdat = '0;
    logic        ack;
    logic [31:0] rdat;
    logic        smp_valid;
    logic        smp_ready = 1'b0;
    logic [15:0] smp_data;
    logic        res_valid = 1'b0;
    logic [15:0] res_data = '0;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wb_nn_port dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .smp_valid_o(smp_valid),
        .smp_ready_i(smp_ready),
        .smp_data_o (smp_data),
        .res_valid_i(res_valid),
        .res_data_i (res_data),
        .irq_o      (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus transfer; starts with an idle edge, ends #1 after the ack cycle
    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic w, output logic acked, output logic [31:0] rd);
        acked = 1'b0;
        rd    = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack) begin
                acked = 1'b1;
                rd    = rdat;
                break;
            end
        end
        if (acked) begin
            @(posedge clk); #1;
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wdat = '0; sel = '0;
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
        logic        k;
        logic [31:0] r;
        xfer(a, d, s, 1'b1, k, r);
        chk({tag, "_ack"}, 32'(k), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic        k;
        logic [31:0] r;
        xfer(a, 32'd0, 4'hF, 1'b0, k, r);
        chk({tag, "_ack"}, 32'(k), 32'd1);
        chk(tag, r, exp);
    endtask

    task automatic pulse(input logic [15:0] d);
        res_valid = 1'b1;
        res_data  = d;
        @(posedge clk); #1;
        res_valid = 1'b0;
        res_data  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic        k;
        logic [31:0] r;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_valid", 32'(smp_valid), 32'd0);
        rst = 1'b0;
        rd_chk("rst_status", A_STAT, 32'h0000_0100);

        // single sample flows straight through
        smp_ready = 1'b1;
        wr("ctrl_en", A_CTRL, 32'h1, 4'hF);
        wr("push1234", A_IN, 32'hDEAD_1234, 4'hF);
        chk("flow_valid", 32'(smp_valid), 32'd1);
        chk("flow_data", 32'(smp_data), 32'h1234);
        @(posedge clk); #1;
        chk("flow_popped", 32'(smp_valid), 32'd0);
        rd_chk("flow_status", A_STAT, 32'h0000_0100);
        smp_ready = 1'b0;

        // fill past depth with enable low
        wr("ctrl_dis", A_CTRL, 32'h0, 4'hF);
        for (int i = 0; i < 9; i++) begin
            wr("fill", A_IN, 32'h00A0 + 32'(i), 4'h1);
        end
        chk("dis_valid", 32'(smp_valid), 32'd0);
        rd_chk("full_status", A_STAT, 32'h0000_0608);
        wr("w1c_sel0", A_STAT, 32'h400, 4'b0001);
        rd_chk("w1c_sel0_status", A_STAT, 32'h0000_0608);
        wr("w1c_sel1", A_STAT, 32'h400, 4'b0010);
        rd_chk("w1c_status", A_STAT, 32'h0000_0208);
        wr("ctrl_en2", A_CTRL, 32'h1, 4'hF);
        chk("head_valid", 32'(smp_valid), 32'd1);
        chk("head_data", 32'(smp_data), 32'h00A0);
        wr("ctrl_clr", A_CTRL, 32'h5, 4'hF);
        chk("clr_valid", 32'(smp_valid), 32'd0);
        rd_chk("clr_status", A_STAT, 32'h0000_0100);
        rd_chk("ctrl_rd", A_CTRL, 32'h1);
        wr("ctrl_nosel", A_CTRL, 32'h0, 4'b0010);
        rd_chk("ctrl_nosel_rd", A_CTRL, 32'h1);

        // result overrun
        pulse(16'h00AA);
        pulse(16'h00BB);
        rd_chk("ovr_status", A_STAT, 32'h0000_1900);
        rd_chk("out_bb", A_OUT, 32'h0000_00BB);
        rd_chk("ovr_after_rd", A_STAT, 32'h0000_1100);
        wr("ovr_w1c", A_STAT, 32'h1000, 4'b0010);
        rd_chk("ovr_cleared", A_STAT, 32'h0000_0100);

        // interrupt timing
        wr("ctrl_irq", A_CTRL, 32'h3, 4'hF);
        chk("irq_idle", 32'(irq), 32'd0);
        pulse(16'h0055);
        chk("irq_lag", 32'(irq), 32'd0);
        @(posedge clk); #1;
        chk("irq_high", 32'(irq), 32'd1);
        rd_chk("out_55", A_OUT, 32'h0000_0055);
        chk("irq_ack_cycle", 32'(irq), 32'd1);
        @(posedge clk); #1;
        chk("irq_low", 32'(irq), 32'd0);

        // result arriving in the OUT_DATA read ack cycle
        pulse(16'h0011);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = A_OUT; sel = 4'hF;
        @(posedge clk); #1;
        chk("coin_ack", 32'(ack), 32'd1);
        res_valid = 1'b1; res_data = 16'h0022;
        chk("coin_old", rdat, 32'h0000_0011);
        @(posedge clk); #1;
        res_valid = 1'b0; res_data = '0;
        chk("coin_noreack", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; adr = '0; sel = '0;
        rd_chk("coin_status", A_STAT, 32'h0000_0900);
        rd_chk("coin_new", A_OUT, 32'h0000_0022);

        // out-of-window and unmapped offsets
        xfer(BASE + 32'h100, 32'd0, 4'hF, 1'b0, k, r);
        chk("oow_noack", 32'(k), 32'd0);
        rd_chk("unmapped", BASE + 32'h10, 32'd0);
        rd_chk("in_rd", A_IN, 32'd0);

        // reset in the middle of a transfer
        wr("p1", A_IN, 32'h1, 4'hF);
        wr("p2", A_IN, 32'h2, 4'hF);
        wr("p3", A_IN, 32'h3, 4'hF);
        rd_chk("cnt3", A_STAT, 32'h0000_0003);
        chk("pre_rst_valid", 32'(smp_valid), 32'd1);
        chk("pre_rst_data", 32'(smp_data), 32'h1);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = A_CTRL; wdat = 32'h0; sel = 4'hF;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_valid", 32'(smp_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid_rst_ack2", 32'(ack), 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; sel = '0;
        rst = 1'b0;
        rd_chk("post_rst_status", A_STAT, 32'h0000_0100);
        rd_chk("post_rst_ctrl", A_CTRL, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
